scytale_decryption: RTL
=======================

# scytale_decryption

Scytale decryption stage, downstream of the decryption register file and selected through the MUX/DEMUX path when `select` = 1. It buffers ciphertext characters until the start-decryption token arrives. It then streams the plaintext out one character per cycle, reordered using the scytale key held in the register file.

## Interface
- `D_WIDTH`, 8, character width
- `KEY_WIDTH`, 16, key width; matches register-file `scytale_key`
- `MAX_NOF_CHARS`, 50, buffer depth in characters
- `START_DECRYPTION_TOKEN`, 8'hFA, terminator character that starts decryption

- `clk`  in  1  clock; all logic on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `data_i`  in  D_WIDTH  ciphertext character
- `valid_i`  in  1  `data_i` qualifier
- `key`  in  KEY_WIDTH  `key[15:8]` = N (columns), `key[7:0]` = M (rows)
- `data_o`  out  D_WIDTH  plaintext character; 0 whenever `valid_o` = 0
- `valid_o`  out  1  `data_o` qualifier
- `busy`  out  1  high while decrypting; input is ignored while high

## Operation
- Reset values: `data_o` = 0, `valid_o` = 0, `busy` = 0, write count `cnt` = 0, state IDLE. Buffer contents are don't-care.
- Reset applied mid-decryption aborts at that edge. No further `valid_o` pulses. Buffered characters are discarded.

States:
- **IDLE (collect):**
  - `valid_i` = 1 and `data_i` != token: store the character at `buf[cnt]`, then `cnt`++.
  - If `cnt` = MAX_NOF_CHARS, the character is dropped and `cnt` holds.
  - `valid_i` = 1 and `data_i` = token with `cnt` > 0: latch N, M and L = `cnt`, compute `match` = (N*M == L), set `busy`, go to SETUP. The token is not stored.
  - Token with `cnt` = 0: ignored; stay in IDLE.
- **SETUP (1 cycle):** clear row `i`, column `j` and pointer `idx`; go to OUT.
- **OUT:**
  - Each cycle: `valid_o` = 1, `data_o` = `buf[idx]`.
  - `match` = 1 (scytale order): output k reads `c[j*M + i]`, with i = k div N and j = k mod N.
    - Multiplier-free update: if `j` = N-1, then `j` = 0, `i`++, `idx` = `i`+1. Otherwise `j`++, `idx` += M.
  - `match` = 0: passthrough. `idx` = k; characters are emitted in received order.
  - After L outputs go to DONE.
- **DONE (1 cycle):** `valid_o` = 0, `busy` = 0, `cnt` = 0; go to IDLE.
- Key changes after the token edge have no effect on the current message.
- `valid_i` is ignored in SETUP, OUT and DONE, including token values.
- Degenerate keys: N = 0 or M = 0 gives `match` = 0, so passthrough. The reset key 16'hFFFF never matches L ≤ 50, so passthrough.

## Timing
- Token sampled at edge T: `busy` = 1 after T.
- First `valid_o` after edge T+1; L consecutive `valid_o` cycles, the last after edge T+L.
- After edge T+L+1: `valid_o` = 0 and `busy` = 0. Input is accepted again from that cycle.
- Total token-to-idle latency is L+2 cycles. There is no backpressure.
- No `valid_o` bubbles inside a message.
- `data_o` is registered and changes only on `clk` edges.
- Widths:
  - `cnt` and `idx`: clog2(MAX_NOF_CHARS+1) bits.
  - N*M: 16-bit product, compared against zero-extended L.
  - `idx` never exceeds L-1 when `match` = 1.

## Test plan
- Nominal decrypt: key 16'h0302; send "ADBECF", then 8'hFA → after 1 idle cycle, `valid_o` for 6 cycles carrying "ABCDEF"; then `busy` = 0.
- Mismatch passthrough: key 16'h0302; send "HELLO", then 8'hFA → "HELLO" in order, 5 `valid_o` cycles.
- Overflow: key 16'h0A05; send 52 characters 0x00..0x33, then token → 50 outputs. The scytale order uses only 0x00..0x31, and output[1] = 0x05.
- Busy lockout and key freeze: during OUT, drive `valid_i` with 'Z' and with 8'hFA, and change `key` to 16'h0101 → output sequence unchanged; no second message; `cnt` = 0 after DONE.
- Reset mid-operation: assert `rst_n` = 0 on the 3rd output cycle → `valid_o` = 0, `busy` = 0 and `data_o` = 0 on the next edge. A fresh "ADBECF"+token then decrypts correctly.
- Empty token: 8'hFA with `cnt` = 0 → `busy` stays 0 and no `valid_o`. A following "AB" + token with key 16'h0201 → "AB".

Source files
------------

// File: rtl/scytale_decryption.sv
// ============================================================================
// Module   : scytale_decryption
// Purpose  : Scytale decryption stage. Collects ciphertext characters into a
//            local buffer until the start-decryption token arrives, then
//            streams the plaintext out one character per cycle, reordered by
//            the scytale key (N columns x M rows). When N*M does not equal the
//            message length the characters are passed through in received
//            order.
// Ports    : clk      - clock, rising edge
//            rst_n    - synchronous active-low reset
//            data_i   - ciphertext character
//            valid_i  - data_i qualifier (ignored while busy)
//            key      - key[15:8] = N (columns), key[7:0] = M (rows)
//            data_o   - plaintext character, 0 when valid_o is low
//            valid_o  - data_o qualifier
//            busy     - high from the token edge until the message is drained
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module scytale_decryption #(
  parameter int                   D_WIDTH                = 8,
  parameter int                   KEY_WIDTH              = 16,
  parameter int                   MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]   START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [D_WIDTH-1:0]    data_i,
  input  logic                  valid_i,
  input  logic [KEY_WIDTH-1:0]  key,
  output logic [D_WIDTH-1:0]    data_o,
  output logic                  valid_o,
  output logic                  busy
);

  localparam int             CW      = $clog2(MAX_NOF_CHARS + 1);
  localparam int             HW      = KEY_WIDTH / 2;
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_NOF_CHARS);
  localparam logic [CW-1:0]  ONE     = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Character buffer; contents are don't-care after reset, so no reset.
  logic [D_WIDTH-1:0] char_mem [MAX_NOF_CHARS];

  logic [CW-1:0] cnt;        // write count while collecting
  logic [CW-1:0] len;        // message length latched at the token
  logic [CW-1:0] idx;        // read pointer of the next character to emit
  logic [CW-1:0] out_cnt;    // index k of the next character to emit
  logic [HW-1:0] n_cols;     // latched N
  logic [HW-1:0] m_rows;     // latched M
  logic [HW-1:0] row;        // i = k div N
  logic [HW-1:0] col;        // j = k mod N
  logic          match;      // N*M == L, scytale order in use

  logic [KEY_WIDTH-1:0] prod;
  logic                 match_now;
  logic                 store_char;
  logic                 token_start;
  logic                 emitting;
  logic                 last_out;

  // Full-width product of the two key halves, compared to zero-extended L.
  assign prod      = {{HW{1'b0}}, key[KEY_WIDTH-1:HW]} * {{HW{1'b0}}, key[HW-1:0]};
  assign match_now = (prod == {{(KEY_WIDTH-CW){1'b0}}, cnt});

  assign store_char  = (state == IDLE) && valid_i &&
                       (data_i != START_DECRYPTION_TOKEN) && (cnt != MAX_CNT);
  assign token_start = (state == IDLE) && valid_i &&
                       (data_i == START_DECRYPTION_TOKEN) && (cnt != '0);

  // SETUP already loads the first character so that valid_o rises one edge
  // after the token edge; OUT loads the remaining ones.
  assign emitting = (state == SETUP) || (state == OUT);
  assign last_out = (out_cnt == (len - ONE));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (token_start) state_nxt = SETUP;
      SETUP, OUT: state_nxt = last_out ? DONE : OUT;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Reset-controlled outputs and write counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          data_o  <= '0;
          valid_o <= 1'b0;
          if (store_char) begin
            cnt <= cnt + ONE;
          end
          if (token_start) begin
            busy <= 1'b1;
          end
        end
        SETUP, OUT: begin
          data_o  <= char_mem[idx];
          valid_o <= 1'b1;
        end
        DONE: begin
          data_o  <= '0;
          valid_o <= 1'b0;
          busy    <= 1'b0;
          cnt     <= '0;
        end
        default: begin
          data_o  <= '0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Buffer write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n && store_char) begin
      char_mem[cnt] <= data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Message context and read-pointer walk
  // --------------------------------------------------------------------------
  // The key and length are frozen at the token edge, so later key changes do
  // not affect the message being drained. The walk pointers are cleared at
  // that same edge, which lets SETUP already read buf[0].
  always_ff @(posedge clk) begin
    if (token_start) begin
      n_cols  <= key[KEY_WIDTH-1:HW];
      m_rows  <= key[HW-1:0];
      len     <= cnt;
      match   <= match_now;
      row     <= '0;
      col     <= '0;
      idx     <= '0;
      out_cnt <= '0;
    end else if (emitting && !last_out) begin
      out_cnt <= out_cnt + ONE;
      if (match) begin
        // Walk c[j*M + i] without a multiplier: along a row the pointer
        // steps by M; at the end of a row it restarts at the next row index.
        if (col == (n_cols - HW'(1))) begin
          col <= '0;
          row <= row + HW'(1);
          idx <= CW'(row + HW'(1));
        end else begin
          col <= col + HW'(1);
          idx <= idx + CW'(m_rows);
        end
      end else begin
        idx <= idx + ONE;
      end
    end
  end

endmodule

`default_nettype wire
